// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: memory request encodings and the
// arbiter's own state and source enumerations.
package memory_arbiter_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    SRC_IFETCH = 1'b0,
    SRC_DATA   = 1'b1
  } mem_arb_source_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Memory request/response bundle. The requester drives the request fields;
// the server answers with req_fulfilled and req_loaded_word.
interface memory_if #(
  parameter int XLEN = 32
);
  import memory_arbiter_pkg::*;

  logic                   req_valid;
  logic [XLEN-1:0]        req_address;
  memory_operation_e      req_operation;
  memory_operation_size_e req_size;
  logic [XLEN-1:0]        req_store_word;
  logic [XLEN-1:0]        req_loaded_word;
  logic                   req_fulfilled;

  modport requester (
    output req_valid, req_address, req_operation, req_size, req_store_word,
    input  req_loaded_word, req_fulfilled
  );

  modport server (
    input  req_valid, req_address, req_operation, req_size, req_store_word,
    output req_loaded_word, req_fulfilled
  );

endinterface

// File: rtl/memory_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the source that did not
// win last time is chosen.
module rr_pick2
  import memory_arbiter_pkg::*;
(
  input  logic            ifetch_valid,
  input  logic            data_valid,
  input  mem_arb_source_e last_grant,
  output logic            grant_valid,
  output mem_arb_source_e grant_src
);

  // Select the winner among the valid sources, alternating on a tie.
  always_comb begin
    grant_valid = ifetch_valid | data_valid;
    grant_src   = SRC_IFETCH;
    if (ifetch_valid && data_valid) begin
      if (last_grant == SRC_DATA) begin
        grant_src = SRC_IFETCH;
      end else begin
        grant_src = SRC_DATA;
      end
    end else if (data_valid) begin
      grant_src = SRC_DATA;
    end else begin
      grant_src = SRC_IFETCH;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-to-one arbiter sharing one memory between instruction fetch and data.
// A grant captures the winner's request into registers, which are presented
// to memory until it reports fulfilled; the response goes to the owner only.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  memory_if.server    imem,
  memory_if.server    dmem,
  memory_if.requester mem,
  output logic       busy
);

  mem_arb_state_e         state_r;
  mem_arb_state_e         next_state_s;
  mem_arb_source_e        last_grant_r;
  logic                   grant_valid_s;
  mem_arb_source_e        grant_src_s;
  logic                   capture_s;
  logic                   release_s;

  logic                   valid_r;
  logic [XLEN-1:0]        address_r;
  memory_operation_e      operation_r;
  memory_operation_size_e size_r;
  logic [XLEN-1:0]        store_word_r;

  logic [XLEN-1:0]        sel_address_s;
  memory_operation_e      sel_operation_s;
  memory_operation_size_e sel_size_s;
  logic [XLEN-1:0]        sel_store_word_s;

  rr_pick2 u_pick (
    .ifetch_valid (imem.req_valid),
    .data_valid   (dmem.req_valid),
    .last_grant   (last_grant_r),
    .grant_valid  (grant_valid_s),
    .grant_src    (grant_src_s)
  );

  // Next-state decision: grant from idle, return to idle on fulfilled.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (grant_valid_s) begin
          capture_s    = 1'b1;
          next_state_s = (grant_src_s == SRC_IFETCH) ? ARB_GRANT_I : ARB_GRANT_D;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (mem.req_fulfilled) begin
          release_s    = 1'b1;
          next_state_s = ARB_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = ARB_IDLE;
      end
    endcase
  end

  // Route the winning source's request fields toward the capture registers.
  always_comb begin
    sel_address_s    = imem.req_address;
    sel_operation_s  = imem.req_operation;
    sel_size_s       = imem.req_size;
    sel_store_word_s = imem.req_store_word;
    if (grant_src_s == SRC_DATA) begin
      sel_address_s    = dmem.req_address;
      sel_operation_s  = dmem.req_operation;
      sel_size_s       = dmem.req_size;
      sel_store_word_s = dmem.req_store_word;
    end else begin
      sel_address_s    = imem.req_address;
      sel_operation_s  = imem.req_operation;
      sel_size_s       = imem.req_size;
      sel_store_word_s = imem.req_store_word;
    end
  end

  // State register and round-robin history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= SRC_DATA;
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        last_grant_r <= grant_src_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Request registers: loaded on grant, cleared on completion so that the
  // memory port shows all zeros whenever no grant is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r      <= 1'b0;
      address_r    <= {XLEN{1'b0}};
      operation_r  <= MEM_LOAD;
      size_r       <= MEM_SIZE_BYTE;
      store_word_r <= {XLEN{1'b0}};
    end else if (capture_s) begin
      valid_r      <= 1'b1;
      address_r    <= sel_address_s;
      operation_r  <= sel_operation_s;
      size_r       <= sel_size_s;
      store_word_r <= sel_store_word_s;
    end else if (release_s) begin
      valid_r      <= 1'b0;
      address_r    <= {XLEN{1'b0}};
      operation_r  <= MEM_LOAD;
      size_r       <= MEM_SIZE_BYTE;
      store_word_r <= {XLEN{1'b0}};
    end else begin
      valid_r      <= valid_r;
      address_r    <= address_r;
      operation_r  <= operation_r;
      size_r       <= size_r;
      store_word_r <= store_word_r;
    end
  end

  assign mem.req_valid      = valid_r;
  assign mem.req_address    = address_r;
  assign mem.req_operation  = operation_r;
  assign mem.req_size       = size_r;
  assign mem.req_store_word = store_word_r;
  assign busy               = valid_r;

  // Responses reach only the owner; a fulfilled pulse while idle is dropped.
  assign imem.req_fulfilled   = (state_r == ARB_GRANT_I) ? mem.req_fulfilled : 1'b0;
  assign imem.req_loaded_word = (state_r == ARB_GRANT_I) ? mem.req_loaded_word : {XLEN{1'b0}};
  assign dmem.req_fulfilled   = (state_r == ARB_GRANT_D) ? mem.req_fulfilled : 1'b0;
  assign dmem.req_loaded_word = (state_r == ARB_GRANT_D) ? mem.req_loaded_word : {XLEN{1'b0}};

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset/idle behaviour, a single data
// load, round-robin alternation, stability of captured fields, reset mid-grant.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int tests_run = 0;
  int tests_failed = 0;

  memory_if #(.XLEN(32)) imem_bus ();
  memory_if #(.XLEN(32)) dmem_bus ();
  memory_if #(.XLEN(32)) mem_bus ();

  memory_arbiter #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .imem    (imem_bus),
    .dmem    (dmem_bus),
    .mem     (mem_bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_bus.req_valid = 1'b0; imem_bus.req_address = 32'h0;
    imem_bus.req_operation = MEM_LOAD; imem_bus.req_size = MEM_SIZE_WORD;
    imem_bus.req_store_word = 32'h0;
    dmem_bus.req_valid = 1'b0; dmem_bus.req_address = 32'h0;
    dmem_bus.req_operation = MEM_LOAD; dmem_bus.req_size = MEM_SIZE_WORD;
    dmem_bus.req_store_word = 32'h0;
    mem_bus.req_fulfilled = 1'b0; mem_bus.req_loaded_word = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({mem_bus.req_valid, busy, imem_bus.req_fulfilled, dmem_bus.req_fulfilled, mem_bus.req_address} !== {4'b0000, 32'h0}) begin
        tests_failed++;
        $display("FAIL reset_idle: valid/busy/if/df=%b%b%b%b addr=%h want 0000 addr 0", mem_bus.req_valid, busy, imem_bus.req_fulfilled, dmem_bus.req_fulfilled, mem_bus.req_address);
      end
    end
    mem_bus.req_fulfilled = 1'b1; mem_bus.req_loaded_word = 32'hCAFEF00D;
    #1;
    tests_run++;
    if ({imem_bus.req_fulfilled, dmem_bus.req_fulfilled, imem_bus.req_loaded_word, dmem_bus.req_loaded_word} !== {2'b00, 64'h0}) begin
      tests_failed++;
      $display("FAIL spurious_fulfilled: if=%b df=%b iw=%h dw=%h want all 0", imem_bus.req_fulfilled, dmem_bus.req_fulfilled, imem_bus.req_loaded_word, dmem_bus.req_loaded_word);
    end
    tick();
    mem_bus.req_fulfilled = 1'b0; mem_bus.req_loaded_word = 32'h0;
    tests_run++;
    if ({mem_bus.req_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL spurious_idle: valid=%b busy=%b want 0 0", mem_bus.req_valid, busy);
    end
  endtask

  task automatic test_single_load();
    dmem_bus.req_valid = 1'b1; dmem_bus.req_address = 32'h100;
    dmem_bus.req_operation = MEM_LOAD; dmem_bus.req_size = MEM_SIZE_WORD;
    #1;
    tests_run++;
    if (mem_bus.req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_latency: valid=%b want 0 in request cycle", mem_bus.req_valid);
    end
    tick();
    tests_run++;
    if ({mem_bus.req_valid, busy, mem_bus.req_address, mem_bus.req_operation, mem_bus.req_size} !== {2'b11, 32'h100, MEM_LOAD, MEM_SIZE_WORD}) begin
      tests_failed++;
      $display("FAIL load_grant: valid=%b busy=%b addr=%h op=%0d size=%0d want 1 1 100 0 2", mem_bus.req_valid, busy, mem_bus.req_address, mem_bus.req_operation, mem_bus.req_size);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({mem_bus.req_valid, dmem_bus.req_fulfilled} !== 2'b10) begin
        tests_failed++;
        $display("FAIL load_wait: valid=%b df=%b want 1 0", mem_bus.req_valid, dmem_bus.req_fulfilled);
      end
    end
    tick();
    mem_bus.req_fulfilled = 1'b1; mem_bus.req_loaded_word = 32'hDEADBEEF;
    #1;
    tests_run++;
    if ({dmem_bus.req_fulfilled, dmem_bus.req_loaded_word, imem_bus.req_fulfilled, imem_bus.req_loaded_word} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL load_response: df=%b dw=%h if=%b iw=%h want 1 deadbeef 0 0", dmem_bus.req_fulfilled, dmem_bus.req_loaded_word, imem_bus.req_fulfilled, imem_bus.req_loaded_word);
    end
    dmem_bus.req_valid = 1'b0;
    tick();
    mem_bus.req_fulfilled = 1'b0; mem_bus.req_loaded_word = 32'h0;
    tests_run++;
    if ({mem_bus.req_valid, busy, mem_bus.req_address} !== {2'b00, 32'h0}) begin
      tests_failed++;
      $display("FAIL load_done: valid=%b busy=%b addr=%h want 0 0 0", mem_bus.req_valid, busy, mem_bus.req_address);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_addr;
    logic [1:0]  exp_ful;
    logic [31:0] got_word;
    clear_inputs();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    imem_bus.req_valid = 1'b1; imem_bus.req_address = 32'h0;
    dmem_bus.req_valid = 1'b1; dmem_bus.req_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h0 : 32'h200;
      exp_ful  = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      tests_run++;
      if ({mem_bus.req_valid, busy, mem_bus.req_address} !== {2'b11, exp_addr}) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: valid=%b busy=%b addr=%h want 1 1 %h", k, mem_bus.req_valid, busy, mem_bus.req_address, exp_addr);
      end
      mem_bus.req_fulfilled = 1'b1; mem_bus.req_loaded_word = 32'h1000 + 32'(k);
      #1;
      got_word = (k % 2 == 0) ? imem_bus.req_loaded_word : dmem_bus.req_loaded_word;
      tests_run++;
      if ({imem_bus.req_fulfilled, dmem_bus.req_fulfilled, got_word} !== {exp_ful, 32'h1000 + 32'(k)}) begin
        tests_failed++;
        $display("FAIL rr_response%0d: if/df=%b%b word=%h want %b word %h", k, imem_bus.req_fulfilled, dmem_bus.req_fulfilled, got_word, exp_ful, 32'h1000 + 32'(k));
      end
      tick();
      mem_bus.req_fulfilled = 1'b0; mem_bus.req_loaded_word = 32'h0;
      tests_run++;
      if ({mem_bus.req_valid, busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rr_bubble%0d: valid=%b busy=%b want 0 0", k, mem_bus.req_valid, busy);
      end
    end
    clear_inputs();
  endtask

  task automatic test_mid_change();
    dmem_bus.req_valid = 1'b1; dmem_bus.req_address = 32'h40;
    dmem_bus.req_operation = MEM_STORE; dmem_bus.req_size = MEM_SIZE_WORD;
    dmem_bus.req_store_word = 32'h11;
    tick();
    tests_run++;
    if ({mem_bus.req_valid, mem_bus.req_operation, mem_bus.req_address, mem_bus.req_store_word} !== {1'b1, MEM_STORE, 32'h40, 32'h11}) begin
      tests_failed++;
      $display("FAIL store_grant: valid=%b op=%0d addr=%h data=%h want 1 1 40 11", mem_bus.req_valid, mem_bus.req_operation, mem_bus.req_address, mem_bus.req_store_word);
    end
    dmem_bus.req_address = 32'h80; dmem_bus.req_store_word = 32'h22;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({mem_bus.req_valid, mem_bus.req_address, mem_bus.req_store_word} !== {1'b1, 32'h40, 32'h11}) begin
        tests_failed++;
        $display("FAIL store_hold%0d: valid=%b addr=%h data=%h want 1 40 11", i, mem_bus.req_valid, mem_bus.req_address, mem_bus.req_store_word);
      end
    end
    mem_bus.req_fulfilled = 1'b1;
    #1;
    tests_run++;
    if ({dmem_bus.req_fulfilled, mem_bus.req_address} !== {1'b1, 32'h40}) begin
      tests_failed++;
      $display("FAIL store_done: df=%b addr=%h want 1 40", dmem_bus.req_fulfilled, mem_bus.req_address);
    end
    dmem_bus.req_valid = 1'b0;
    tick();
    mem_bus.req_fulfilled = 1'b0;
    tests_run++;
    if ({mem_bus.req_valid, mem_bus.req_store_word} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL store_idle: valid=%b data=%h want 0 0", mem_bus.req_valid, mem_bus.req_store_word);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    imem_bus.req_valid = 1'b1; imem_bus.req_address = 32'h300;
    tick();
    tests_run++;
    if ({mem_bus.req_valid, mem_bus.req_address} !== {1'b1, 32'h300}) begin
      tests_failed++;
      $display("FAIL rst_grant: valid=%b addr=%h want 1 300", mem_bus.req_valid, mem_bus.req_address);
    end
    tick();
    reset_n = 1'b0; mem_bus.req_fulfilled = 1'b1;
    #1;
    tests_run++;
    if ({mem_bus.req_valid, busy, imem_bus.req_fulfilled, dmem_bus.req_fulfilled, mem_bus.req_address} !== {4'b0000, 32'h0}) begin
      tests_failed++;
      $display("FAIL rst_async: valid/busy/if/df=%b%b%b%b addr=%h want 0000 0", mem_bus.req_valid, busy, imem_bus.req_fulfilled, dmem_bus.req_fulfilled, mem_bus.req_address);
    end
    mem_bus.req_fulfilled = 1'b0;
    tick();
    dmem_bus.req_valid = 1'b1; dmem_bus.req_address = 32'h500;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if ({mem_bus.req_valid, mem_bus.req_address} !== {1'b1, 32'h300}) begin
      tests_failed++;
      $display("FAIL rst_tie_ifetch: valid=%b addr=%h want 1 300", mem_bus.req_valid, mem_bus.req_address);
    end
    mem_bus.req_fulfilled = 1'b1;
    #1;
    imem_bus.req_valid = 1'b0;
    tick();
    mem_bus.req_fulfilled = 1'b0;
    tick();
    tests_run++;
    if ({mem_bus.req_valid, busy, mem_bus.req_address} !== {2'b11, 32'h500}) begin
      tests_failed++;
      $display("FAIL rst_then_data: valid=%b busy=%b addr=%h want 1 1 500", mem_bus.req_valid, busy, mem_bus.req_address);
    end
    mem_bus.req_fulfilled = 1'b1;
    #1;
    dmem_bus.req_valid = 1'b0;
    tick();
    clear_inputs();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    dmem_bus.req_valid = 1'b1; dmem_bus.req_address = 32'h700;
    tick();
    tests_run++;
    if ({mem_bus.req_valid, mem_bus.req_address, imem_bus.req_fulfilled} !== {1'b1, 32'h700, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_data_alone: valid=%b addr=%h if=%b want 1 700 0", mem_bus.req_valid, mem_bus.req_address, imem_bus.req_fulfilled);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_simultaneous();
    test_mid_change();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
